// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the FP-unit sequencer/arbiter.
// Holds the state encoding, the quiet-NaN pattern and port indices.
package fpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

endpackage

// File: rtl/controle_ponto_flt_arb_rr2.sv
// arb_rr2: two-input round-robin arbiter, purely combinational.
// Ports: req[1:0], last_grant, enable in; grant[1:0] one-hot, winner out.
module arb_rr2
    import fpu_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       winner
);

    always_comb begin
        winner = P0;
        grant  = 2'b00;
        if (req == 2'b11) begin
            // Contention: whoever was not served last time wins.
            winner = ~last_grant;
        end else if (req[1]) begin
            winner = P1;
        end
        if (enable && (|req)) begin
            grant = winner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/controle_ponto_flt.sv
// Sequencer/arbiter sharing the FP unit between two requesters.
// Ports: clk, rst_n (sync, active-low); per port req/a/b/mul in,
// ack/resp_valid/resp_s/resp_err out; fpu_a/b/multiplicando/start
// out, fpu_finish/fpu_s in; busy out.
// Optional: FPC_WATCHDOG_EN enables the WAIT-state timeout.
module controle_ponto_flt
    import fpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic        mul0,
    output logic        ack0,
    output logic        resp0_valid,
    output logic [31:0] resp0_s,
    output logic        resp0_err,
    input  logic        req1,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic        mul1,
    output logic        ack1,
    output logic        resp1_valid,
    output logic [31:0] resp1_s,
    output logic        resp1_err,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic        fpu_multiplicando,
    output logic        fpu_start,
    input  logic        fpu_finish,
    input  logic [31:0] fpu_s,
    output logic        busy
);

    // Counter width must be able to hold the timeout value.
    if ((2 ** CNT_W) <= TIMEOUT_CYC) begin : g_cnt_too_narrow
    end

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic       owner;
    logic       win;
    logic [1:0] gnt;
    logic       take;
    logic       fin;

    // Gate with rst_n so nothing is acked in a cycle whose edge resets.
    arb_rr2 u_arb (
        .req       ({req1, req0}),
        .last_grant(last_grant),
        .enable    ((state == IDLE) && rst_n),
        .grant     (gnt),
        .winner    (win)
    );

    assign take = |gnt;
    assign fin  = (state == WAIT) && fpu_finish;

`ifdef FPC_WATCHDOG_EN
    logic [CNT_W-1:0] cnt;
    logic             tmo;
    logic             err0_q;
    logic             err1_q;

    // Counter reads 0 in the first WAIT cycle; comparing against
    // TIMEOUT_CYC-2 puts DONE exactly TIMEOUT_CYC cycles after START.
    assign tmo = (state == WAIT) && !fpu_finish &&
                 (cnt == CNT_W'(TIMEOUT_CYC - 2));
    assign resp0_err = err0_q;
    assign resp1_err = err1_q;
`else
    assign resp0_err = 1'b0;
    assign resp1_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (take) state_nxt = SETTLE;
            SETTLE: state_nxt = START;
            START:  state_nxt = WAIT;
            WAIT: begin
                if (fin) state_nxt = DONE;
`ifdef FPC_WATCHDOG_EN
                else if (tmo) state_nxt = DONE;
`endif
            end
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            last_grant        <= P1;
            owner             <= P0;
            fpu_a             <= '0;
            fpu_b             <= '0;
            fpu_multiplicando <= 1'b0;
            resp0_s           <= '0;
            resp1_s           <= '0;
`ifdef FPC_WATCHDOG_EN
            cnt               <= '0;
            err0_q            <= 1'b0;
            err1_q            <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (take) begin
                last_grant        <= win;
                owner             <= win;
                fpu_a             <= win ? a1 : a0;
                fpu_b             <= win ? b1 : b0;
                fpu_multiplicando <= win ? mul1 : mul0;
            end
            if (fin) begin
                if (owner == P1) resp1_s <= fpu_s;
                else             resp0_s <= fpu_s;
            end
`ifdef FPC_WATCHDOG_EN
            if (state == START) cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 1'b1;
            if (fin) begin
                if (owner == P1) err1_q <= 1'b0;
                else             err0_q <= 1'b0;
            end else if (tmo) begin
                if (owner == P1) begin
                    resp1_s <= QNAN;
                    err1_q  <= 1'b1;
                end else begin
                    resp0_s <= QNAN;
                    err0_q  <= 1'b1;
                end
            end
`endif
        end
    end

    assign ack0        = gnt[0];
    assign ack1        = gnt[1];
    assign fpu_start   = (state == START);
    assign busy        = (state != IDLE);
    assign resp0_valid = (state == DONE) && (owner == P0);
    assign resp1_valid = (state == DONE) && (owner == P1);

endmodule

// File: tb/tb_controle_ponto_flt.sv
// Randomized self-checking bench for controle_ponto_flt.
// Transaction-level model: RR winner, fixed latency, stable operands.
module tb_controle_ponto_flt;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, mul0, ack0, resp0_valid, resp0_err;
    logic        req1, mul1, ack1, resp1_valid, resp1_err;
    logic [31:0] a0, b0, resp0_s, a1, b1, resp1_s;
    logic [31:0] fpu_a, fpu_b, fpu_s;
    logic        fpu_multiplicando, fpu_start, fpu_finish, busy;

    always #5 clk = ~clk;

    controle_ponto_flt #(.TIMEOUT_CYC(TMO), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .mul0(mul0), .ack0(ack0),
        .resp0_valid(resp0_valid), .resp0_s(resp0_s),
        .resp0_err(resp0_err),
        .req1(req1), .a1(a1), .b1(b1), .mul1(mul1), .ack1(ack1),
        .resp1_valid(resp1_valid), .resp1_s(resp1_s),
        .resp1_err(resp1_err),
        .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_multiplicando(fpu_multiplicando),
        .fpu_start(fpu_start), .fpu_finish(fpu_finish),
        .fpu_s(fpu_s), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops;
        a0   = $urandom; b0 = $urandom; mul0 = 1'($urandom);
        a1   = $urandom; b1 = $urandom; mul1 = 1'($urandom);
    endtask

    // Reference model state
    int          m_last;
    logic [31:0] m_rs0, m_rs1;

    initial begin
        int          w, d, rst_at, end_i, n;
        bit          r0, r1, early, tmo, force_both, after_rst;
        logic [31:0] ea, eb, rs, exp_s;
        logic        em;

        rst_n = 1'b0;
        req0 = 0; req1 = 0; fpu_finish = 0; fpu_s = '0;
        rand_ops();
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(fpu_start), 0);
        chk("rst_fpu_a", fpu_a, 0);
        chk("rst_fpu_b", fpu_b, 0);
        chk("rst_mul", 32'(fpu_multiplicando), 0);
        chk("rst_rs0", resp0_s, 0);
        chk("rst_rs1", resp1_s, 0);
        chk("rst_vld", 32'({resp0_valid, resp1_valid}), 0);
        chk("rst_err", 32'({resp0_err, resp1_err}), 0);
        m_last = 1; m_rs0 = '0; m_rs1 = '0;
        after_rst = 1'b1;

        for (int op = 0; op < 48; op++) begin
            force_both = (op < 4) || after_rst;
            after_rst  = 1'b0;

            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) begin
                req0 = 0; req1 = 0;
                fpu_finish = 1'($urandom);
                rand_ops();
                #1;
                chk("idle_busy", 32'(busy), 0);
                chk("idle_ack", 32'({ack0, ack1}), 0);
                tick();
            end

            // Grant cycle
            if (force_both) begin
                r0 = 1; r1 = 1;
            end else begin
                n  = $urandom_range(1, 3);
                r0 = n[0]; r1 = n[1];
            end
            req0 = r0; req1 = r1;
            fpu_finish = 1'($urandom);
            rand_ops();
            #1;
            w = (r0 && r1) ? 1 - m_last : (r1 ? 1 : 0);
            chk("ack0", 32'(ack0), 32'(w == 0));
            chk("ack1", 32'(ack1), 32'(w == 1));
            chk("grant_busy", 32'(busy), 0);
            ea = w ? a1 : a0;
            eb = w ? b1 : b0;
            em = w ? mul1 : mul0;
            m_last = w;
            tick();

            d     = $urandom_range(3, 14);
            early = 1'($urandom);
            rs    = $urandom;
`ifdef FPC_WATCHDOG_EN
            end_i = (d > TMO + 1) ? TMO + 1 : d;
            tmo   = (d > TMO + 1);
`else
            end_i = d;
            tmo   = 1'b0;
`endif
            rst_at = (op % 7 == 6) ? $urandom_range(3, end_i) : 0;
            exp_s  = tmo ? 32'h7FC00000 : rs;

            for (int i = 1; i <= end_i + 1; i++) begin
                req0 = 1'($urandom); req1 = 1'($urandom);
                rand_ops();
                fpu_finish = (i == d) || (early && (i == 1 || i == 2));
                fpu_s      = (i == d) ? rs : $urandom;
                rst_n      = (i == rst_at) ? 1'b0 : 1'b1;
                #1;
                chk("hold_a", fpu_a, ea);
                chk("hold_b", fpu_b, eb);
                chk("hold_mul", 32'(fpu_multiplicando), 32'(em));
                chk("busy", 32'(busy), 1);
                chk("op_ack", 32'({ack0, ack1}), 0);
                if (i <= end_i) begin
                    chk("start", 32'(fpu_start), 32'(i == 2));
                    chk("vld_early", 32'({resp0_valid, resp1_valid}), 0);
                end else begin
                    chk("start_done", 32'(fpu_start), 0);
                    chk("vld0", 32'(resp0_valid), 32'(w == 0));
                    chk("vld1", 32'(resp1_valid), 32'(w == 1));
                    if (w == 0) begin
                        chk("rs_own", resp0_s, exp_s);
                        chk("err_own", 32'(resp0_err), 32'(tmo));
                        chk("rs_other", resp1_s, m_rs1);
                        m_rs0 = exp_s;
                    end else begin
                        chk("rs_own", resp1_s, exp_s);
                        chk("err_own", 32'(resp1_err), 32'(tmo));
                        chk("rs_other", resp0_s, m_rs0);
                        m_rs1 = exp_s;
                    end
                end
                tick();
                if (i == rst_at) begin
                    rst_n = 1'b1;
                    req0 = 0; req1 = 0; fpu_finish = 0;
                    #1;
                    chk("mrst_busy", 32'(busy), 0);
                    chk("mrst_start", 32'(fpu_start), 0);
                    chk("mrst_vld", 32'({resp0_valid, resp1_valid}), 0);
                    chk("mrst_rs0", resp0_s, 0);
                    chk("mrst_rs1", resp1_s, 0);
                    chk("mrst_fpu_a", fpu_a, 0);
                    m_last = 1; m_rs0 = '0; m_rs1 = '0;
                    after_rst = 1'b1;
                    tick();
                    break;
                end
            end
            fpu_finish = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
